// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer and 3-byte stream packet decoder.
// Drives the host controller command interface through reset / sample-rate /
// enable, retrying whole attempts on failure, then decodes movement packets.
module ps2_mouse_sequencer #(
  parameter logic [7:0]  SAMPLE_RATE  = 8'd100,
  parameter logic [23:0] RESP_TIMEOUT = 24'd5000000,
  parameter logic [23:0] PKT_TIMEOUT  = 24'd1000000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       init_done,
  output logic       init_error,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [1:0] overflow,
  output logic       packet_valid
);

  // Timer is wide enough for the 4x self-test wait.
  localparam int unsigned TMR_W   = 26;
  localparam int unsigned RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;

  localparam logic [1:0] STEP_RST  = 2'd0;
  localparam logic [1:0] STEP_SR   = 2'd1;
  localparam logic [1:0] STEP_RATE = 2'd2;
  localparam logic [1:0] STEP_EN   = 2'd3;

  typedef enum logic [2:0] {
    ST_SEND,    // raise send_command with the current step's byte
    ST_BUSY,    // hold request until controller accepts or fails it
    ST_RESP,    // collect the expected response byte(s)
    ST_STREAM,  // init complete, assemble packets
    ST_FAIL     // all attempts exhausted
  } state_t;

  state_t             state;
  logic [1:0]         step;
  logic [1:0]         resp_idx;
  logic               resent;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TMR_W-1:0]   timer;
  logic [23:0]        pkt_timer;
  logic [1:0]         byte_cnt;
  logic [7:0]         b0;
  logic [7:0]         b1;

  logic [7:0]         step_cmd;
  logic [7:0]         exp_byte;
  logic [TMR_W-1:0]   resp_limit;
  logic               last_resp;
  logic               byte_ok;
  logic               resend_ok;
  logic               retry_last;
  logic               attempt_fail;

  // Per-step command byte, expected response, wait limit and failure detection.
  always_comb begin
    step_cmd   = 8'hFF;
    exp_byte   = 8'hFA;
    resp_limit = TMR_W'(RESP_TIMEOUT);
    unique case (step)
      STEP_SR:   step_cmd = 8'hF3;
      STEP_RATE: step_cmd = SAMPLE_RATE;
      STEP_EN:   step_cmd = 8'hF4;
      default:   step_cmd = 8'hFF;
    endcase
    if (step == STEP_RST) begin
      if (resp_idx == 2'd1) begin
        exp_byte   = 8'hAA;
        resp_limit = {RESP_TIMEOUT, 2'b00};
      end else if (resp_idx == 2'd2) begin
        exp_byte = 8'h00;
      end
    end
    last_resp  = (step != STEP_RST) || (resp_idx == 2'd2);
    byte_ok    = (received_data == exp_byte);
    resend_ok  = (received_data == 8'hFE) && !resent;
    retry_last = (retry_cnt == RETRY_W'(MAX_RETRY - 1));
    attempt_fail = 1'b0;
    if (state == ST_BUSY) begin
      attempt_fail = error_communication_timed_out && !command_was_sent;
    end else if (state == ST_RESP) begin
      if (received_data_en) begin
        attempt_fail = !byte_ok && !resend_ok;
      end else begin
        attempt_fail = (timer >= resp_limit);
      end
    end
  end

  // Init sequencer, retry bookkeeping and stream packet assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SEND;
      step         <= STEP_RST;
      resp_idx     <= 2'd0;
      resent       <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
      pkt_timer    <= '0;
      byte_cnt     <= 2'd0;
      b0           <= 8'h00;
      b1           <= 8'h00;
      the_command  <= 8'h00;
      send_command <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
      buttons      <= 3'd0;
      dx           <= 9'd0;
      dy           <= 9'd0;
      overflow     <= 2'd0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      if (restart) begin
        state        <= ST_SEND;
        step         <= STEP_RST;
        resp_idx     <= 2'd0;
        resent       <= 1'b0;
        retry_cnt    <= '0;
        timer        <= '0;
        pkt_timer    <= '0;
        byte_cnt     <= 2'd0;
        send_command <= 1'b0;
        init_done    <= 1'b0;
        init_error   <= 1'b0;
      end else if (attempt_fail) begin
        send_command <= 1'b0;
        resp_idx     <= 2'd0;
        resent       <= 1'b0;
        timer        <= '0;
        if (retry_last) begin
          state      <= ST_FAIL;
          init_error <= 1'b1;
        end else begin
          retry_cnt <= retry_cnt + RETRY_W'(1);
          step      <= STEP_RST;
          state     <= ST_SEND;
        end
      end else begin
        unique case (state)
          ST_SEND: begin
            the_command  <= step_cmd;
            send_command <= 1'b1;
            state        <= ST_BUSY;
          end
          ST_BUSY: begin
            if (command_was_sent) begin
              send_command <= 1'b0;
              timer        <= '0;
              resp_idx     <= 2'd0;
              state        <= ST_RESP;
            end
          end
          ST_RESP: begin
            timer <= received_data_en ? '0 : timer + TMR_W'(1);
            if (received_data_en) begin
              if (byte_ok) begin
                if (last_resp) begin
                  resp_idx <= 2'd0;
                  resent   <= 1'b0;
                  if (step == STEP_EN) begin
                    state     <= ST_STREAM;
                    init_done <= 1'b1;
                    byte_cnt  <= 2'd0;
                    pkt_timer <= '0;
                  end else begin
                    step  <= step + 2'd1;
                    state <= ST_SEND;
                  end
                end else begin
                  resp_idx <= resp_idx + 2'd1;
                end
              end else begin
                // Only reachable on a first 0xFE: re-issue the same command.
                resent <= 1'b1;
                state  <= ST_SEND;
              end
            end
          end
          ST_STREAM: begin
            if (received_data_en) begin
              pkt_timer <= '0;
              unique case (byte_cnt)
                2'd0: begin
                  // Bit 3 is always set in a header byte; anything else is misaligned.
                  if (received_data[3]) begin
                    b0       <= received_data;
                    byte_cnt <= 2'd1;
                  end
                end
                2'd1: begin
                  b1       <= received_data;
                  byte_cnt <= 2'd2;
                end
                default: begin
                  byte_cnt     <= 2'd0;
                  buttons      <= b0[2:0];
                  dx           <= {b0[4], b1};
                  dy           <= {b0[5], received_data};
                  overflow     <= {b0[7], b0[6]};
                  packet_valid <= 1'b1;
                end
              endcase
            end else if (byte_cnt != 2'd0) begin
              if (pkt_timer >= PKT_TIMEOUT) begin
                byte_cnt  <= 2'd0;
                pkt_timer <= '0;
              end else begin
                pkt_timer <= pkt_timer + 24'd1;
              end
            end
          end
          ST_FAIL: begin
            send_command <= 1'b0;
          end
          default: begin
            state <= ST_SEND;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Directed bench for ps2_mouse_sequencer with a behavioural controller+mouse model.
module tb_ps2_mouse_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       restart = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       init_done;
  logic       init_error;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [1:0] overflow;
  logic       packet_valid;

  int total = 0;
  int bad = 0;

  // Model state: written only by the model process.
  logic [7:0] cmd_log [0:63];
  int         ncmd = 0;
  int         stream_rd = 0;
  // Model controls: written only by the main process.
  int         silent_upto = 0;
  int         fe_idx = -1;
  int         stream_buf [0:31];
  int         stream_wr = 0;
  int         pv_cnt = 0;

  ps2_mouse_sequencer #(
    .SAMPLE_RATE (8'd100),
    .RESP_TIMEOUT(24'd40),
    .PKT_TIMEOUT (24'd30),
    .MAX_RETRY   (3)
  ) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .restart                      (restart),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data                (received_data),
    .received_data_en             (received_data_en),
    .init_done                    (init_done),
    .init_error                   (init_error),
    .buttons                      (buttons),
    .dx                           (dx),
    .dy                           (dy),
    .overflow                     (overflow),
    .packet_valid                 (packet_valid)
  );

  always #5 clk = ~clk;

  // Counts packet_valid cycles; a stretched pulse would count twice.
  always @(negedge clk) begin
    if (reset_n && packet_valid === 1'b1) pv_cnt <= pv_cnt + 1;
  end

  task automatic drive_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  // Controller + mouse: acks commands after 3 cycles, answers per protocol.
  initial begin : mouse_model
    logic [7:0] cmd;
    logic       aborted;
    int         idx;
    int         entry;
    logic [7:0] sb;
    forever begin
      @(negedge clk);
      if (send_command === 1'b1) begin
        cmd = the_command;
        idx = ncmd;
        if (ncmd < 64) cmd_log[ncmd] = cmd;
        ncmd = ncmd + 1;
        aborted = 1'b0;
        for (int k = 0; k < 3 && !aborted; k++) begin
          @(negedge clk);
          if (send_command !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          command_was_sent = 1'b1;
          @(negedge clk);
          command_was_sent = 1'b0;
          if (idx >= silent_upto) begin
            if (cmd == 8'hF3 && idx == fe_idx) begin
              drive_byte(8'hFE);
            end else begin
              drive_byte(8'hFA);
              if (cmd == 8'hFF) begin
                drive_byte(8'hAA);
                drive_byte(8'h00);
              end
            end
          end
        end
      end else if (stream_rd < stream_wr) begin
        entry = stream_buf[stream_rd];
        stream_rd = stream_rd + 1;
        repeat (entry >> 8) @(negedge clk);
        sb = entry[7:0];
        drive_byte(sb);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    stream_buf[stream_wr] = (gap << 8) | int'(b);
    stream_wr++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && stream_rd < stream_wr; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check(tag, 32'(stream_rd == stream_wr), 32'd1);
  endtask

  task automatic pulse_restart;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin : main
    int pv0;
    int base;
    // Reset values
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_command", 32'(send_command), 32'd0);
    check("rst_the_command", 32'(the_command), 32'h00);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_error", 32'(init_error), 32'd0);
    check("rst_packet_valid", 32'(packet_valid), 32'd0);
    check("rst_dx", 32'(dx), 32'd0);
    check("rst_dy", 32'(dy), 32'd0);
    check("rst_buttons_ovf", 32'({buttons, overflow}), 32'd0);
    reset_n = 1'b1;

    // Normal bring-up: FF, F3, 64, F4
    for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);
    check("init_error_clear", 32'(init_error), 32'd0);
    check("init_cmd_count", 32'(ncmd), 32'd4);
    check("init_cmd0", 32'(cmd_log[0]), 32'hFF);
    check("init_cmd1", 32'(cmd_log[1]), 32'hF3);
    check("init_cmd2", 32'(cmd_log[2]), 32'h64);
    check("init_cmd3", 32'(cmd_log[3]), 32'hF4);
    check("stream_send_idle", 32'(send_command), 32'd0);

    // Packet: left button, dx=+5, dy=-5 (Y sign bit set in header)
    pv0 = pv_cnt;
    push(8'h29, 0); push(8'h05, 0); push(8'hFB, 0);
    drain("pkt1_drain");
    check("pkt1_pulses", 32'(pv_cnt - pv0), 32'd1);
    check("pkt1_buttons", 32'(buttons), 32'h1);
    check("pkt1_dx", 32'(dx), 32'h005);
    check("pkt1_dy", 32'(dy), 32'h1FB);
    check("pkt1_ovf", 32'(overflow), 32'h0);
    repeat (20) @(negedge clk);
    check("pkt1_hold_dx", 32'(dx), 32'h005);
    check("pkt_valid_low", 32'(packet_valid), 32'd0);

    // Misaligned header byte discarded, then X sign set
    pv0 = pv_cnt;
    push(8'h00, 0); push(8'h18, 0); push(8'h80, 0); push(8'h01, 0);
    drain("pkt2_drain");
    check("pkt2_pulses", 32'(pv_cnt - pv0), 32'd1);
    check("pkt2_dx", 32'(dx), 32'h180);
    check("pkt2_dy", 32'(dy), 32'h001);
    check("pkt2_buttons", 32'(buttons), 32'h0);

    // Partial packet dropped by inter-byte timeout
    pv0 = pv_cnt;
    push(8'h08, 0); push(8'h01, 0);
    push(8'h08, 40); push(8'h01, 0); push(8'h02, 0);
    drain("pkt3_drain");
    check("pkt3_pulses", 32'(pv_cnt - pv0), 32'd1);
    check("pkt3_dx", 32'(dx), 32'h001);
    check("pkt3_dy", 32'(dy), 32'h002);

    // All buttons, both overflow bits, Y sign only
    pv0 = pv_cnt;
    push(8'hEF, 0); push(8'h7F, 0); push(8'h80, 0);
    drain("pkt4_drain");
    check("pkt4_pulses", 32'(pv_cnt - pv0), 32'd1);
    check("pkt4_buttons", 32'(buttons), 32'h7);
    check("pkt4_dx", 32'(dx), 32'h07F);
    check("pkt4_dy", 32'(dy), 32'h180);
    check("pkt4_ovf", 32'(overflow), 32'h3);

    // Restart with first FF unanswered (one retry used), then restart again mid-F3
    silent_upto = ncmd + 1;
    pulse_restart();
    check("rst1_init_done", 32'(init_done), 32'd0);
    check("rst1_hold_dx", 32'(dx), 32'h07F);
    for (int i = 0; i < 2000 && !(send_command === 1'b1 && the_command === 8'hF3); i++)
      @(negedge clk);
    check("f3_in_flight", 32'({send_command, the_command}), 32'h1F3);
    silent_upto = 1000;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst2_send_low", 32'(send_command), 32'd0);
    base = ncmd;
    @(negedge clk);
    check("rst2_next_cmd", 32'({send_command, the_command}), 32'h1FF);
    // Silent mouse: full MAX_RETRY attempts from a cleared retry count
    for (int i = 0; i < 3000 && init_error !== 1'b1; i++) @(negedge clk);
    check("fail_init_error", 32'(init_error), 32'd1);
    check("fail_init_done", 32'(init_done), 32'd0);
    check("fail_attempts", 32'(ncmd - base), 32'd3);
    repeat (20) @(negedge clk);
    check("fail_send_idle", 32'(send_command), 32'd0);

    // One 0xFE to F3: F3 resent once, init completes
    silent_upto = 0;
    fe_idx = ncmd + 1;
    base = ncmd;
    pulse_restart();
    check("rst3_init_error", 32'(init_error), 32'd0);
    for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clk);
    check("fe_init_done", 32'(init_done), 32'd1);
    check("fe_cmd_count", 32'(ncmd - base), 32'd5);
    check("fe_cmd1", 32'(cmd_log[base + 1]), 32'hF3);
    check("fe_cmd2", 32'(cmd_log[base + 2]), 32'hF3);
    check("fe_cmd3", 32'(cmd_log[base + 3]), 32'h64);
    check("fe_cmd4", 32'(cmd_log[base + 4]), 32'hF4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
